// File: rtl/apb_pkg.sv
// Shared APB definitions: default bus widths and the master FSM state encoding.
package apb_pkg;

    localparam int AMBA_WORD_DEFAULT       = 32;
    localparam int AMBA_ADDR_WIDTH_DEFAULT = 20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational, last-grant pointer is registered.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       en,
    output logic [1:0] grant
);

    // 1 means requester 1 won most recently; reset value lets requester 0 win first
    logic last;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (valid == 2'b11) grant = last ? 2'b01 : 2'b10;
            else                grant = valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      last <= 1'b1;
        else if (|grant) last <= grant[1];
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Two-requester APB master: round-robin grant, zero-wait-state SETUP/ACCESS sequencing.
module apb_req_arbiter
    import apb_pkg::*;
#(
    parameter int AMBA_WORD       = AMBA_WORD_DEFAULT,
    parameter int AMBA_ADDR_WIDTH = AMBA_ADDR_WIDTH_DEFAULT
) (
    input  logic                       PCLK,
    input  logic                       PRESETn,
    input  logic                       req0_valid,
    input  logic                       req0_write,
    input  logic [AMBA_ADDR_WIDTH-1:0] req0_addr,
    input  logic [AMBA_WORD-1:0]       req0_wdata,
    output logic                       req0_ready,
    output logic                       req0_done,
    output logic [AMBA_WORD-1:0]       req0_rdata,
    input  logic                       req1_valid,
    input  logic                       req1_write,
    input  logic [AMBA_ADDR_WIDTH-1:0] req1_addr,
    input  logic [AMBA_WORD-1:0]       req1_wdata,
    output logic                       req1_ready,
    output logic                       req1_done,
    output logic [AMBA_WORD-1:0]       req1_rdata,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic                       PENABLE,
    output logic                       PSEL,
    output logic [AMBA_WORD-1:0]       PWDATA,
    output logic                       PWRITE,
    input  logic [AMBA_WORD-1:0]       PRDATA
);

    apb_state_e           state, state_nxt;
    logic [1:0]           grant;
    logic                 arb_en;
    logic                 owner;
    logic [1:0]           done_q;
    logic [AMBA_WORD-1:0] rdata_q [2];

    // A new grant is only possible when the bus is free next cycle: from IDLE or in the closing ACCESS
    assign arb_en = PRESETn && (state == IDLE || state == ACCESS);

    rr_arb2 u_arb (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .valid ({req1_valid, req0_valid}),
        .en    (arb_en),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign req0_done  = done_q[0];
    assign req1_done  = done_q[1];
    assign req0_rdata = rdata_q[0];
    assign req1_rdata = rdata_q[1];

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        case (state)
            IDLE:   if (|grant) state_nxt = SETUP;
            SETUP: begin
                PSEL      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                PSEL      = 1'b1;
                PENABLE   = 1'b1;
                state_nxt = (|grant) ? SETUP : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PADDR  <= '0;
            PWDATA <= '0;
            PWRITE <= 1'b0;
            owner  <= 1'b0;
        end else if (|grant) begin
            PADDR  <= grant[1] ? req1_addr  : req0_addr;
            PWDATA <= grant[1] ? req1_wdata : req0_wdata;
            PWRITE <= grant[1] ? req1_write : req0_write;
            owner  <= grant[1];
        end
    end

    // Completion is reported the cycle after ACCESS; writes return zero data
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            done_q     <= 2'b00;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
        end else begin
            done_q <= 2'b00;
            if (state == ACCESS) begin
                done_q[owner]  <= 1'b1;
                rdata_q[owner] <= PWRITE ? '0 : PRDATA;
            end
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Randomized bench against a transfer-timeline model, plus directed literal scenarios.
module tb_apb_req_arbiter;

    localparam int AW = 20;
    localparam int DW = 32;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          v [2];
    logic          w [2];
    logic [AW-1:0] a [2];
    logic [DW-1:0] d [2];
    logic          req0_ready, req1_ready, req0_done, req1_done;
    logic [DW-1:0] req0_rdata, req1_rdata;
    logic [AW-1:0] PADDR;
    logic          PENABLE, PSEL, PWRITE;
    logic [DW-1:0] PWDATA, PRDATA;

    apb_req_arbiter #(.AMBA_WORD(DW), .AMBA_ADDR_WIDTH(AW)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req0_valid(v[0]), .req0_write(w[0]), .req0_addr(a[0]), .req0_wdata(d[0]),
        .req0_ready(req0_ready), .req0_done(req0_done), .req0_rdata(req0_rdata),
        .req1_valid(v[1]), .req1_write(w[1]), .req1_addr(a[1]), .req1_wdata(d[1]),
        .req1_ready(req1_ready), .req1_done(req1_done), .req1_rdata(req1_rdata),
        .PADDR(PADDR), .PENABLE(PENABLE), .PSEL(PSEL), .PWDATA(PWDATA),
        .PWRITE(PWRITE), .PRDATA(PRDATA)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a transfer granted in cycle g occupies SETUP at g+1, ACCESS at g+2, done at g+3
    int            cyc;
    bit            m_active;
    int            m_g;
    int            m_who;
    int            m_last;
    bit            m_dpend;
    int            m_dwho;
    logic [AW-1:0] m_paddr;
    logic [DW-1:0] m_pwdata;
    logic          m_pwrite;
    logic [DW-1:0] m_rdata [2];
    bit            m_gr [2];

    task automatic model_reset();
        m_active = 0; m_last = 1; m_dpend = 0; m_dwho = 0;
        m_paddr = '0; m_pwdata = '0; m_pwrite = 1'b0;
        m_rdata[0] = '0; m_rdata[1] = '0;
        m_gr[0] = 0; m_gr[1] = 0;
    endtask

    task automatic model_step();
        int  ph;
        int  win;
        bit  can;
        bit  rst;
        rst = !PRESETn;
        if (rst) model_reset();
        ph  = m_active ? cyc - m_g : -1;
        can = !rst && (!m_active || ph == 2);
        win = -1;
        if (can) begin
            if (v[0] && v[1]) win = 1 - m_last;
            else if (v[0])    win = 0;
            else if (v[1])    win = 1;
        end
        m_gr[0] = (win == 0);
        m_gr[1] = (win == 1);
        chk("ready0", req0_ready, m_gr[0]);
        chk("ready1", req1_ready, m_gr[1]);
        chk("done0", req0_done, m_dpend && m_dwho == 0);
        chk("done1", req1_done, m_dpend && m_dwho == 1);
        chk("rdata0", req0_rdata, m_rdata[0]);
        chk("rdata1", req1_rdata, m_rdata[1]);
        chk("psel", PSEL, m_active && (ph == 1 || ph == 2));
        chk("penable", PENABLE, m_active && ph == 2);
        chk("paddr", PADDR, m_paddr);
        chk("pwdata", PWDATA, m_pwdata);
        chk("pwrite", PWRITE, m_pwrite);
        if (rst) return;
        m_dpend = 0;
        if (m_active && ph == 2) begin
            m_dpend = 1;
            m_dwho  = m_who;
            m_rdata[m_who] = m_pwrite ? '0 : PRDATA;
            m_active = 0;
        end
        if (win >= 0) begin
            m_active = 1; m_g = cyc; m_who = win; m_last = win;
            m_paddr = a[win]; m_pwdata = d[win]; m_pwrite = w[win];
        end
    endtask

    task automatic cycle();
        @(negedge PCLK);
        model_step();
        @(posedge PCLK);
        #1;
        cyc++;
    endtask

    task automatic req(input int r, input logic vv, input logic ww, input logic [AW-1:0] aa,
                       input logic [DW-1:0] dd);
        v[r] = vv; w[r] = ww; a[r] = aa; d[r] = dd;
    endtask

    task automatic check_bus_zero(input string nm);
        chk({nm, "_psel"}, PSEL, 1'b0);
        chk({nm, "_penable"}, PENABLE, 1'b0);
        chk({nm, "_paddr"}, PADDR, '0);
        chk({nm, "_pwdata"}, PWDATA, '0);
        chk({nm, "_pwrite"}, PWRITE, 1'b0);
    endtask

    bit pend [2];

    initial begin
        cyc = 0;
        PRESETn = 1'b0;
        PRDATA = '0;
        for (int r = 0; r < 2; r++) req(r, 0, 0, '0, '0);
        model_reset();
        repeat (2) @(posedge PCLK);
        #1;
        check_bus_zero("reset");
        chk("reset_ready0", req0_ready, 1'b0);
        chk("reset_done0", req0_done, 1'b0);
        chk("reset_rdata1", req1_rdata, '0);
        cycle();
        PRESETn = 1'b1;
        cycle();

        // Single write from requester 0
        req(0, 1, 1, 20'h00004, 32'hA5A5A5A5);
        #1 chk("w_ready0_c0", req0_ready, 1'b1);
        cycle();
        req(0, 0, 0, '0, '0);
        #1;
        chk("w_psel_c1", PSEL, 1'b1);
        chk("w_penable_c1", PENABLE, 1'b0);
        chk("w_paddr_c1", PADDR, 20'h00004);
        chk("w_pwdata_c1", PWDATA, 32'hA5A5A5A5);
        chk("w_pwrite_c1", PWRITE, 1'b1);
        cycle();
        #1;
        chk("w_psel_c2", PSEL, 1'b1);
        chk("w_penable_c2", PENABLE, 1'b1);
        chk("w_paddr_c2", PADDR, 20'h00004);
        cycle();
        #1;
        chk("w_done0_c3", req0_done, 1'b1);
        chk("w_rdata0_c3", req0_rdata, 32'h0);
        chk("w_psel_c3", PSEL, 1'b0);
        cycle();

        // Single read from requester 1
        req(1, 1, 0, 20'h0000C, 32'h0);
        #1 chk("r_ready1_c0", req1_ready, 1'b1);
        cycle();
        req(1, 0, 0, '0, '0);
        cycle();
        PRDATA = 32'h12345678;
        #1;
        chk("r_penable_c2", PENABLE, 1'b1);
        chk("r_pwrite_c2", PWRITE, 1'b0);
        chk("r_paddr_c2", PADDR, 20'h0000C);
        cycle();
        PRDATA = '0;
        #1;
        chk("r_done1_c3", req1_done, 1'b1);
        chk("r_rdata1_c3", req1_rdata, 32'h12345678);
        chk("r_done0_c3", req0_done, 1'b0);
        cycle();

        // Both requesters valid continuously after a fresh reset
        PRESETn = 1'b0;
        cycle();
        PRESETn = 1'b1;
        cycle();
        for (int i = 0; i < 8; i++) begin
            req(0, 1, 1, AW'(20'h100 + i), DW'(i));
            req(1, 1, 0, AW'(20'h200 + i), DW'(0));
            #1;
            chk("rr_ready0", req0_ready, (i % 4) == 0);
            chk("rr_ready1", req1_ready, (i % 4) == 2);
            chk("rr_psel", PSEL, i > 0);
            cycle();
        end
        req(0, 0, 0, '0, '0);
        req(1, 0, 0, '0, '0);
        repeat (4) cycle();

        // Back-to-back transfers from requester 0 only
        for (int i = 0; i < 6; i++) begin
            if (i < 5) req(0, 1, i[0], AW'(20'h300 + i), DW'(32'hC0DE0000 + i));
            else       req(0, 0, 0, '0, '0);
            #1;
            chk("b2b_ready0", req0_ready, (i % 2) == 0 && i < 5);
            chk("b2b_psel", PSEL, i > 0);
            cycle();
        end
        repeat (3) cycle();

        // Reset while ACCESS is on the bus
        req(0, 1, 1, 20'h00ABC, 32'hDEADBEEF);
        #1 chk("ra_ready0", req0_ready, 1'b1);
        cycle();
        req(0, 0, 0, '0, '0);
        cycle();
        chk("ra_penable_pre", PENABLE, 1'b1);
        PRESETn = 1'b0;
        #1;
        check_bus_zero("ra");
        chk("ra_ready0", req0_ready, 1'b0);
        cycle();
        #1 chk("ra_done0", req0_done, 1'b0);
        PRESETn = 1'b1;
        req(0, 1, 0, 20'h00010, '0);
        req(1, 1, 0, 20'h00020, '0);
        #1;
        chk("ra_first_ready0", req0_ready, 1'b1);
        chk("ra_first_ready1", req1_ready, 1'b0);
        cycle();
        req(0, 0, 0, '0, '0);
        req(1, 0, 0, '0, '0);
        repeat (6) cycle();

        // Randomized traffic; a pending request is held until the model grants it
        pend[0] = 0; pend[1] = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (m_gr[r]) pend[r] = 0;
                if (!pend[r]) begin
                    if ($urandom_range(0, 99) < 45) begin
                        pend[r] = 1;
                        req(r, 1, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
                    end else begin
                        req(r, 0, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
                    end
                end else if ($urandom_range(0, 99) < 3) begin
                    pend[r] = 0;
                    v[r] = 1'b0;
                end
            end
            PRDATA = $urandom;
            if ($urandom_range(0, 999) == 0) PRESETn = 1'b0;
            else PRESETn = 1'b1;
            cycle();
        end
        PRESETn = 1'b1;
        req(0, 0, 0, '0, '0);
        req(1, 0, 0, '0, '0);
        repeat (5) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 SHALL have parameter AMBA_WORD, default 32, APB data width.
REQ-002 SHALL have parameter AMBA_ADDR_WIDTH, default 20, APB address width.
REQ-003 SHALL have port PCLK  in  1  single clock; all logic rising-edge.
REQ-004 SHALL have port PRESETn  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports reqN_valid  in  1  requester N (N=0,1) has a transfer pending.
REQ-006 SHALL have ports reqN_write  in  1  1=write, 0=read.
REQ-007 SHALL have ports reqN_addr  in  AMBA_ADDR_WIDTH  transfer address.
REQ-008 SHALL have ports reqN_wdata  in  AMBA_WORD  write data.
REQ-009 SHALL have ports reqN_ready  out  1  request accepted this cycle.
REQ-010 SHALL have ports reqN_done  out  1  one-cycle completion pulse.
REQ-011 SHALL have ports reqN_rdata  out  AMBA_WORD  read data, valid with reqN_done.
REQ-012 SHALL have ports PADDR, PENABLE, PSEL, PWDATA, PWRITE out and PRDATA in, with widths as the shared APB bus (master side).

Function
REQ-013 SHALL implement FSM states IDLE, SETUP, ACCESS.
REQ-014 IDLE: PSEL=0, PENABLE=0; if any reqN_valid, grant one, pulse its reqN_ready, latch write/addr/wdata into PWRITE/PADDR/PWDATA, go to SETUP.
REQ-015 SETUP: PSEL=1, PENABLE=0; unconditionally go to ACCESS next cycle.
REQ-016 ACCESS: PSEL=1, PENABLE=1; transfer completes in this cycle (bus has no wait states); PRDATA sampled at the closing edge.
REQ-017 ACCESS with any reqN_valid SHALL grant, pulse reqN_ready, latch new fields and go directly to SETUP (2 cycles/transfer back-to-back); otherwise go to IDLE.
REQ-018 Arbitration SHALL be round-robin between 2 requesters: single valid wins; both valid -> the requester not granted last wins.
REQ-019 reqN_ready SHALL be asserted only when reqN_valid=1, and never for both requesters in the same cycle.
REQ-020 PADDR, PWDATA, PWRITE SHALL be registered, change only on grant, and hold their values in IDLE.
REQ-021 reqN_done SHALL pulse for exactly one cycle, the cycle after the owning ACCESS cycle.
REQ-022 reqN_rdata SHALL be registered: PRDATA for reads, all-zero for writes; held until the next done for that requester.
REQ-023 Requesters SHALL hold valid and fields stable until ready; a valid withdrawn before ready is ignored.
REQ-024 A requester MAY re-assert valid in its done cycle; it is eligible for arbitration that cycle.
REQ-025 PSEL and PENABLE SHALL never be asserted in any state other than SETUP/ACCESS as above.

Reset
REQ-026 PRESETn low SHALL immediately force FSM=IDLE, PSEL=0, PENABLE=0, PADDR=0, PWDATA=0, PWRITE=0, all ready/done=0, rdata=0.
REQ-027 The round-robin pointer SHALL reset so requester 0 wins the first simultaneous request.
REQ-028 Reset during SETUP/ACCESS SHALL abort the transfer; no done pulse is issued for it.

Structure
REQ-029 AMBA_WORD, AMBA_ADDR_WIDTH defaults and the FSM state enum SHALL reside in shared package apb_pkg.
REQ-030 Round-robin selection SHALL be a sub-module rr_arb2 (inputs 2 valids + enable, outputs one-hot grant, owns last-grant register).

Verification
REQ-031 Single write: req0 write addr 0x00004 data 0xA5A5A5A5 -> ready0 cycle 0, SETUP cycle 1, ACCESS cycle 2 with exact values, done0 cycle 3, rdata0=0.
REQ-032 Single read: req1 read addr 0x0000C, PRDATA=0x12345678 in ACCESS -> done1 next cycle with rdata1=0x12345678.
REQ-033 Simultaneous after reset: both valid continuously -> grants 0,1,0,1, each transfer 2 cycles, PSEL stays high throughout.
REQ-034 Back-to-back same requester: req0 valid held for 3 transfers, req1 idle -> 3 grants to req0, no IDLE cycle between transfers.
REQ-035 Reset mid-ACCESS: PRESETn low in ACCESS -> all outputs 0 at once, no done; after release, first simultaneous request goes to req0.
